// File: rtl/stream_release_pipeline_if.sv
// ---------------------------------------------------------------------------
// stream_release_pipeline_if
//
// AXI4-Stream beat bundle used on both sides of stream_release_pipeline.
//
// Signals:
//   tvalid  beat valid (source -> sink)
//   tready  sink ready (sink -> source)
//   tlast   last beat of a packet
//   tdata   STREAM_WIDTH-bit payload
//   tkeep   KEEP_WIDTH-bit byte qualifiers
//
// Modports:
//   master  the side that produces beats (drives tvalid/tlast/tdata/tkeep)
//   slave   the side that consumes beats (drives tready)
// ---------------------------------------------------------------------------
interface stream_release_pipeline_if #(
    parameter int STREAM_WIDTH = 32,
    parameter int KEEP_WIDTH   = 1
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [STREAM_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]   tkeep;

    modport master (
        output tvalid,
        output tlast,
        output tdata,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tlast,
        input  tdata,
        input  tkeep,
        output tready
    );
endinterface

// File: rtl/stream_release_pipeline.sv
// ---------------------------------------------------------------------------
// stream_release_pipeline
//
// Consumer side of the rasterizer stream semaphore. Beats admitted on s_axis
// travel through a fixed LATENCY-stage delay line with no internal
// backpressure, land in a FIFO_DEPTH-entry output FIFO and leave on m_axis.
// Every beat that leaves the FIFO produces a one-cycle sig_release pulse,
// which feeds the semaphore's release input and closes its credit loop.
//
// A local credit counter (occupancy) covers the delay line plus the FIFO, so
// s_axis_tready drops before the FIFO could ever be overrun, even if the
// upstream semaphore is configured with too many credits.
//
// Ports:
//   aclk                clock, all logic on the rising edge
//   reset               synchronous, active-high reset
//   s_axis              slave stream port (incoming beats)
//   m_axis              master stream port (outgoing beats)
//   test_bypass_credit  test hook: when 1, a valid input beat is accepted even
//                       with no credit left; tie to 0 in normal use
//   sig_release         registered 1-cycle pulse per beat popped on m_axis
//   occupancy           beats currently in the delay line plus the FIFO
//   overflow_err        sticky; a FIFO write found the FIFO full
// ---------------------------------------------------------------------------
module stream_release_pipeline #(
    parameter int STREAM_WIDTH = 32,
    parameter int KEEP_WIDTH   = 1,
    parameter int LATENCY      = 4,
    parameter int FIFO_DEPTH   = 128
) (
    input  logic                            aclk,
    input  logic                            reset,
    stream_release_pipeline_if.slave        s_axis,
    stream_release_pipeline_if.master       m_axis,
    input  logic                            test_bypass_credit,
    output logic                            sig_release,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy,
    output logic                            overflow_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PAY_W = STREAM_WIDTH + KEEP_WIDTH + 1;

    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

    // Credit and status registers
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             sig_release_q, sig_release_d;
    logic             overflow_err_q, overflow_err_d;

    // Delay line: one valid bit and one {tlast, tkeep, tdata} word per stage
    logic [LATENCY-1:0] line_valid_q, line_valid_d;
    logic [PAY_W-1:0]   line_pay_q [LATENCY];
    logic [PAY_W-1:0]   line_pay_d [LATENCY];

    // Output FIFO storage and pointers (extra MSB separates full from empty)
    logic [PAY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    logic             credit_ok;
    logic             accept;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             line_out_valid;
    logic             fifo_write;
    logic             fifo_drop;
    logic [PAY_W-1:0] in_payload;
    logic [PAY_W-1:0] head_payload;

    // Handshake decode and FIFO status. tready comes only from the registered
    // occupancy so there is no combinational path from m_axis to s_axis.
    always_comb begin
        credit_ok      = (occupancy_q < OCC_MAX);
        accept         = s_axis.tvalid & (credit_ok | test_bypass_credit);
        fifo_empty     = (wr_ptr_q == rd_ptr_q);
        fifo_full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                         (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop            = !fifo_empty & m_axis.tready;
        line_out_valid = line_valid_q[LATENCY-1];
        // A beat reaching the end of the line while the FIFO is full can only
        // happen if the credit check was bypassed; it is discarded.
        fifo_write     = line_out_valid & !fifo_full;
        fifo_drop      = line_out_valid & fifo_full;
        in_payload     = {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        head_payload   = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    assign s_axis.tready = credit_ok;
    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tlast  = head_payload[PAY_W-1];
    assign m_axis.tkeep  = head_payload[PAY_W-2 -: KEEP_WIDTH];
    assign m_axis.tdata  = head_payload[STREAM_WIDTH-1:0];

    assign sig_release   = sig_release_q;
    assign occupancy     = occupancy_q;
    assign overflow_err  = overflow_err_q;

    // Delay line next state: stage 0 takes the accepted beat, every other
    // stage copies its predecessor each cycle regardless of downstream state.
    always_comb begin
        line_valid_d    = '0;
        line_valid_d[0] = accept;
        line_pay_d[0]   = in_payload;
        for (int i = 1; i < LATENCY; i++) begin
            line_valid_d[i] = line_valid_q[i-1];
            line_pay_d[i]   = line_pay_q[i-1];
        end
    end

    // FIFO pointers, credit counter and status next state. Occupancy is
    // clamped to [0, FIFO_DEPTH] so a bypassed accept cannot wrap it.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occupancy_d    = occupancy_q;
        sig_release_d  = pop;
        overflow_err_d = overflow_err_q | fifo_drop;

        if (fifo_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (accept && !pop && (occupancy_q != OCC_MAX)) begin
            occupancy_d = occupancy_q + OCC_ONE;
        end else if (pop && !accept && (occupancy_q != '0)) begin
            occupancy_d = occupancy_q - OCC_ONE;
        end
    end

    // Control state: everything that must be clean after reset.
    always_ff @(posedge aclk) begin
        if (reset) begin
            line_valid_q   <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occupancy_q    <= '0;
            sig_release_q  <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            line_valid_q   <= line_valid_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occupancy_q    <= occupancy_d;
            sig_release_q  <= sig_release_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    // Delay-line payload registers are qualified by the valid bits, so they
    // carry no reset.
    always_ff @(posedge aclk) begin
        line_pay_q <= line_pay_d;
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge aclk) begin
        if (!reset && fifo_write) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= line_pay_q[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_stream_release_pipeline.sv
// ---------------------------------------------------------------------------
// tb_stream_release_pipeline
//
// Drives stream_release_pipeline (LATENCY=4, FIFO_DEPTH=8) with directed and
// random beats and compares every output, every cycle, against a queue-based
// reference model: accepted beats sit in an in-flight list until their
// due cycle, then move into a bounded output queue.
// ---------------------------------------------------------------------------
module tb_stream_release_pipeline;

    localparam int SW    = 32;
    localparam int KW    = 1;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [SW-1:0] data;
    } beat_t;

    typedef struct {
        beat_t b;
        int    due;
    } flight_t;

    logic             aclk = 1'b0;
    logic             reset;
    logic             test_bypass_credit;
    logic             sig_release;
    logic [OCC_W-1:0] occupancy;
    logic             overflow_err;

    stream_release_pipeline_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) s_if ();
    stream_release_pipeline_if #(.STREAM_WIDTH(SW), .KEEP_WIDTH(KW)) m_if ();

    stream_release_pipeline #(
        .STREAM_WIDTH (SW),
        .KEEP_WIDTH   (KW),
        .LATENCY      (LAT),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .aclk               (aclk),
        .reset              (reset),
        .s_axis             (s_if.slave),
        .m_axis             (m_if.master),
        .test_bypass_credit (test_bypass_credit),
        .sig_release        (sig_release),
        .occupancy          (occupancy),
        .overflow_err       (overflow_err)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    beat_t   fifo_q[$];
    flight_t flight_q[$];
    int      m_occ;
    logic    m_ovf;
    logic    m_rel;
    int      cyc;
    int      pops;
    int      rel_seen;

    int total;
    int bad;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs against the model,
    // take the edge, then advance the model by the same edge.
    task automatic applyStimulus(input logic v, input beat_t b, input logic rdy,
                                 input logic hook, output logic acc);
        logic m_accept;
        logic m_pop;
        logic full_pre;
        s_if.tvalid        = v;
        s_if.tlast         = b.last;
        s_if.tkeep         = b.keep;
        s_if.tdata         = b.data;
        m_if.tready        = rdy;
        test_bypass_credit = hook;
        #1;
        checkOutput("s_tready", 64'(s_if.tready), 64'(m_occ < DEPTH));
        checkOutput("m_tvalid", 64'(m_if.tvalid), 64'(fifo_q.size() != 0));
        if (fifo_q.size() != 0)
            checkOutput("m_payload", 64'({m_if.tlast, m_if.tkeep, m_if.tdata}), 64'(fifo_q[0]));
        checkOutput("occupancy", 64'(occupancy), 64'(m_occ));
        checkOutput("sig_release", 64'(sig_release), 64'(m_rel));
        checkOutput("overflow_err", 64'(overflow_err), 64'(m_ovf));
        if (sig_release === 1'b1) rel_seen++;

        m_accept = v && ((m_occ < DEPTH) || hook);
        m_pop    = rdy && (fifo_q.size() != 0);
        @(posedge aclk);

        full_pre = (fifo_q.size() == DEPTH);
        m_rel    = m_pop;
        if (m_pop) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (flight_q.size() != 0 && flight_q[0].due == cyc) begin
            if (full_pre) m_ovf = 1'b1;
            else          fifo_q.push_back(flight_q[0].b);
            void'(flight_q.pop_front());
        end
        if (m_accept) begin
            flight_t f;
            f.b   = b;
            f.due = cyc + LAT;
            flight_q.push_back(f);
        end
        if (m_accept && !m_pop && m_occ < DEPTH)      m_occ++;
        else if (m_pop && !m_accept && m_occ > 0)     m_occ--;
        cyc++;
        acc = m_accept;
        @(negedge aclk);
    endtask

    task automatic doReset(input int n);
        reset              = 1'b1;
        s_if.tvalid        = 1'b0;
        m_if.tready        = 1'b0;
        test_bypass_credit = 1'b0;
        repeat (n) @(posedge aclk);
        @(negedge aclk);
        reset = 1'b0;
        fifo_q.delete();
        flight_q.delete();
        m_occ = 0;
        m_ovf = 1'b0;
        m_rel = 1'b0;
    endtask

    function automatic beat_t randBeat();
        beat_t r;
        r.data = $urandom;
        r.keep = KW'($urandom_range(0, 1));
        r.last = 1'($urandom_range(0, 1));
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        beat_t idle_b;
        beat_t one_b;
        beat_t cur;
        logic  acc;
        logic  have;
        int    sent;
        int    guard;
        int    rel_base;
        int    pop_base;

        total = 0; bad = 0; cyc = 0; pops = 0; rel_seen = 0;
        idle_b = '0;
        s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
        doReset(3);

        // Reset state and a single beat through the pipe
        applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        one_b.data = 32'hA5A5_0001; one_b.keep = 1'b1; one_b.last = 1'b1;
        applyStimulus(1'b1, one_b, 1'b1, 1'b0, acc);
        repeat (8) applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);

        // Fill with the sink stalled
        repeat (12) applyStimulus(1'b1, randBeat(), 1'b0, 1'b0, acc);
        #1;
        checkOutput("fill_occupancy", 64'(occupancy), 64'(DEPTH));
        checkOutput("fill_tready", 64'(s_if.tready), 64'd0);
        checkOutput("fill_tvalid", 64'(m_if.tvalid), 64'd1);
        @(negedge aclk);

        // One pop at full, then refill the freed credit
        applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b0, acc);
        repeat (5) applyStimulus(1'b0, idle_b, 1'b0, 1'b0, acc);

        // Forced write while full, then drain to confirm contents intact
        applyStimulus(1'b1, randBeat(), 1'b0, 1'b1, acc);
        repeat (6) applyStimulus(1'b0, idle_b, 1'b0, 1'b0, acc);
        #1;
        checkOutput("overflow_latched", 64'(overflow_err), 64'd1);
        @(negedge aclk);
        repeat (12) applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        doReset(1);
        applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);

        // 1000 random beats with random valid/ready duty
        rel_base = rel_seen;
        pop_base = pops;
        sent = 0; guard = 0; have = 1'b0; cur = '0;
        while (sent < 1000 && guard < 20000) begin
            if (!have && $urandom_range(0, 1) == 1) begin
                cur  = randBeat();
                have = 1'b1;
            end
            applyStimulus(have, cur, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        checkOutput("stream_sent", 64'(sent), 64'd1000);
        repeat (40) applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        checkOutput("stream_pops", 64'(pops - pop_base), 64'd1000);
        checkOutput("stream_releases", 64'(rel_seen - rel_base), 64'd1000);
        #1;
        checkOutput("stream_occ_end", 64'(occupancy), 64'd0);
        checkOutput("stream_ovf_end", 64'(overflow_err), 64'd0);
        @(negedge aclk);

        // Reset with 3 beats in the delay line and 2 in the FIFO
        repeat (5) applyStimulus(1'b1, randBeat(), 1'b0, 1'b0, acc);
        applyStimulus(1'b0, idle_b, 1'b0, 1'b0, acc);
        doReset(1);
        rel_base = rel_seen;
        repeat (6) applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        checkOutput("reset_no_release", 64'(rel_seen - rel_base), 64'd0);
        applyStimulus(1'b1, randBeat(), 1'b1, 1'b0, acc);
        repeat (8) applyStimulus(1'b0, idle_b, 1'b1, 1'b0, acc);
        checkOutput("post_reset_release", 64'(rel_seen - rel_base), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_release_pipeline.md
Name: stream_release_pipeline

Overview:
- Downstream consumer of the stream semaphore in the rasterizer command/data path.
- Takes the AXIS beats the semaphore admits, carries them through a fixed-latency LATENCY-stage delay line, and buffers the results in an output FIFO.
- Pulses sig_release once per beat that leaves the FIFO. The semaphore's sigRelease input is driven from this pulse, which closes its credit loop.
- Also applies its own credit check, so it never overflows even when misconfigured.

Parameters:
STREAM_WIDTH, 32, data width of s_axis/m_axis
KEEP_WIDTH, 1, tkeep width
LATENCY, 4, delay-line stages (>=1)
FIFO_DEPTH, 128, output FIFO entries (power of two, >=2)

Ports:
aclk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input last
s_axis_tdata  in  STREAM_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input keep
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
m_axis_tdata  out  STREAM_WIDTH  output data
m_axis_tkeep  out  KEEP_WIDTH  output keep
sig_release  out  1  registered 1-cycle pulse per popped beat
occupancy  out  clog2(FIFO_DEPTH+1)  beats in delay line plus FIFO
overflow_err  out  1  sticky; FIFO write attempted while full

Behaviour:
- Clock and reset: one clock, aclk. reset is synchronous and active-high.
- Reset values, taking effect on the reset edge:
  - all delay-line valid bits 0; FIFO rd/wr pointers 0
  - occupancy 0, sig_release 0, overflow_err 0
  - m_axis_tvalid therefore 0 and s_axis_tready 1
- Delay-line data registers are not reset.
- Credit:
  - s_axis_tready = (occupancy < FIFO_DEPTH), decoded combinationally from the registered occupancy.
  - accept = s_axis_tvalid & s_axis_tready.
  - pop = m_axis_tvalid & m_axis_tready.
- occupancy update per edge:
  - +1 on accept only
  - -1 on pop only
  - unchanged on both or neither
- Occupancy never exceeds FIFO_DEPTH and never underflows.
- Delay line:
  - {tlast, tkeep, tdata, valid} shifts one stage per edge unconditionally; no backpressure inside the line.
  - Stage 0 loads the accepted beat; valid=0 when there is no accept.
  - A beat accepted at edge t is written into the FIFO at edge t+LATENCY.
  - Because of the credit check, the FIFO always has room at write time.
  - If a write arrives while the FIFO is full, the beat is dropped, overflow_err is set and stays set until reset, and the pointers are unchanged.
- FIFO:
  - Circular buffer with wrapping pointers; full/empty distinguished by an extra pointer MSB.
  - m_axis_tvalid = !empty. m_axis_t* are driven from the entry at the read pointer.
  - Write and pop in the same cycle: both occur, and the count is unchanged.
  - A write into an empty FIFO becomes visible on m_axis in the cycle after the write edge. Minimum accept-to-tvalid is therefore LATENCY cycles.
- Ordering: beats leave in acceptance order; tlast and tkeep are preserved bit-exact.
- sig_release:
  - Registered: high for exactly one cycle after each pop edge.
  - Consecutive pops give consecutive high cycles, one per beat.
  - Never asserted for beats dropped by reset or by overflow.
- Reset mid-operation:
  - In-flight and buffered beats are discarded with no release pulses.
  - The upstream semaphore must be reset in the same cycle.
- AXIS rule: m_axis_tvalid, once high, stays high with stable data until the pop (the FIFO head does not change without a pop).

Test Plan:
- Single beat, LATENCY=4, m_axis_tready=1:
  - accept tdata=0xA5A5_0001, tlast=1 at edge 0 -> m_axis_tvalid first high in cycle after edge 4 with identical payload
  - sig_release high exactly one cycle after the pop edge
  - occupancy sequence 1,1,1,1,1,0
- Fill, FIFO_DEPTH=8, m_axis_tready=0, s_axis_tvalid held 1:
  - exactly 8 beats accepted, then s_axis_tready=0 and occupancy=8
  - after 4 more cycles, FIFO full with m_axis_tvalid=1
  - overflow_err stays 0
- At full (occupancy=8), assert m_axis_tready for one cycle -> one pop, sig_release pulse, occupancy 7, s_axis_tready=1; next accept returns occupancy to 8.
- Streaming 1000 random beats with random 50% valid/ready duty:
  - output equals input order and payload
  - sig_release pulse count equals 1000
  - occupancy ends at 0
  - overflow_err 0
- Reset asserted with 3 beats in the delay line and 2 in the FIFO:
  - next cycle m_axis_tvalid=0, occupancy=0, s_axis_tready=1
  - no sig_release afterwards
  - a new beat then traverses with latency 4
- Force a write while full via a test hook (bypass credit) -> overflow_err latches 1, FIFO contents unchanged, cleared only by reset.
